// File: rtl/riscv_pkg.sv
// Shared fetch-stage types and constants.
package riscv_pkg;

    localparam int XLEN = 32;

    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;  // addi x0,x0,0

    // Execute-stage branch verdict encoding; 2'b11 is reserved and treated as NONE.
    localparam logic [1:0] PC_SEL_NONE  = 2'b00;
    localparam logic [1:0] PC_SEL_NT    = 2'b01;
    localparam logic [1:0] PC_SEL_TAKEN = 2'b10;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        HOLD,
        DRAIN
    } fetch_state_t;

    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc;
    } fetch_entry_t;

    // Fetch addresses are always word aligned.
    function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] a);
        return a & ~32'h3;
    endfunction

endpackage

// File: rtl/fetch_skid_buffer.sv
// One-entry holding register for an instruction that arrived while decode was stalled.
module fetch_skid_buffer
    import riscv_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic         clear,
    input  logic         drain,
    input  fetch_entry_t din,
    output fetch_entry_t dout,
    output logic         valid
);

    // Clear (redirect) and drain (handed to IF/ID) both empty the entry; load fills it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
            dout  <= '0;
        end else if (clear || drain) begin
            valid <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
            dout  <= din;
        end
    end

endmodule

// File: rtl/pc_fetch_unit.sv
// Instruction-fetch stage: PC, imem request handshake, IF/ID register and delivery counter.
module pc_fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_ack,
    input  logic        stall_d,
    input  logic [1:0]  pc_branch_en_sel,
    input  logic [31:0] branch_target_e,
    output logic [31:0] instr_d,
    output logic [31:0] pc_d,
    output logic        valid_d,
    output logic [31:0] fetch_count
);
    import riscv_pkg::*;

    fetch_state_t state;
    logic [31:0]  pc;
    logic [31:0]  pc_inc;
    logic [31:0]  redirect_pc;
    logic         redirect;
    logic         skid_load;
    logic         skid_clear;
    logic         skid_drain;
    logic         skid_valid;
    fetch_entry_t skid_din;
    fetch_entry_t skid_dout;

    assign redirect    = (pc_branch_en_sel == PC_SEL_TAKEN);
    assign redirect_pc = align_word(branch_target_e);
    assign pc_inc      = pc + 32'd4;  // wraps modulo 2^32

    // Ack while decode is stalled parks the word; a redirect discards whatever is parked.
    assign skid_load  = !redirect && (state == FETCH) && imem_ack && stall_d;
    assign skid_clear = redirect;
    assign skid_drain = !redirect && (state == HOLD) && !stall_d;
    assign skid_din   = '{instr: imem_rdata, pc: pc};

    fetch_skid_buffer u_skid (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (skid_load),
        .clear (skid_clear),
        .drain (skid_drain),
        .din   (skid_din),
        .dout  (skid_dout),
        .valid (skid_valid)
    );

    // Fetch FSM with registered request outputs, PC, IF/ID register and delivery counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            pc          <= RESET_PC;
            imem_req    <= 1'b0;
            imem_addr   <= RESET_PC;
            instr_d     <= NOP_INSTR;
            pc_d        <= '0;
            valid_d     <= 1'b0;
            fetch_count <= '0;
        end else if (redirect) begin
            // Redirect wins over stall and ack; IF/ID always takes a bubble.
            pc      <= redirect_pc;
            instr_d <= NOP_INSTR;
            valid_d <= 1'b0;
            imem_req <= 1'b1;
            if ((state == FETCH || state == DRAIN) && !imem_ack) begin
                // Outstanding request cannot be withdrawn: keep the old address until acked.
                state <= DRAIN;
            end else begin
                state     <= FETCH;
                imem_addr <= redirect_pc;
            end
        end else begin
            case (state)
                IDLE: begin
                    state     <= FETCH;
                    imem_req  <= 1'b1;
                    imem_addr <= pc;
                end
                FETCH: begin
                    if (imem_ack) begin
                        pc        <= pc_inc;
                        imem_addr <= pc_inc;
                        if (!stall_d) begin
                            instr_d     <= imem_rdata;
                            pc_d        <= pc;
                            valid_d     <= 1'b1;
                            fetch_count <= fetch_count + 32'd1;
                        end else begin
                            state    <= HOLD;
                            imem_req <= 1'b0;
                        end
                    end else if (!stall_d) begin
                        instr_d <= NOP_INSTR;
                        valid_d <= 1'b0;
                    end
                end
                HOLD: begin
                    if (!stall_d) begin
                        instr_d     <= skid_valid ? skid_dout.instr : NOP_INSTR;
                        pc_d        <= skid_dout.pc;
                        valid_d     <= skid_valid;
                        fetch_count <= fetch_count + {31'd0, skid_valid};
                        state       <= FETCH;
                        imem_req    <= 1'b1;
                        imem_addr   <= pc;
                    end
                end
                DRAIN: begin
                    if (!stall_d) begin
                        instr_d <= NOP_INSTR;
                        valid_d <= 1'b0;
                    end
                    if (imem_ack) begin
                        // Stale word is dropped; resume at the redirected PC.
                        state     <= FETCH;
                        imem_addr <= pc;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Bench for pc_fetch_unit: directed scenarios plus an instruction-stream model checked every cycle.
module tb_pc_fetch_unit;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req, imem_ack, stall_d, valid_d;
    logic [31:0] imem_addr, imem_rdata, branch_target_e, instr_d, pc_d, fetch_count;
    logic [1:0]  pc_branch_en_sel;

    // Second instance exercising the PC wrap from a high reset vector.
    logic        h_req, h_valid;
    logic [31:0] h_addr, h_rdata, h_instr, h_pc, h_cnt;

    int checks = 0;
    int errors = 0;
    int ws;
    int wcnt;

    always #5 clk = ~clk;

    // Memory content: a pure function of address, so any delivered word can be predicted.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hC0DE_0000;
    endfunction

    // Memory with a programmable number of wait states.
    assign imem_ack   = imem_req && (wcnt >= ws);
    assign imem_rdata = imem_ack ? mem_word(imem_addr) : 32'hDEAD_BEEF;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)                   wcnt <= 0;
        else if (!imem_req || imem_ack) wcnt <= 0;
        else                          wcnt <= wcnt + 1;
    end

    assign h_rdata = mem_word(h_addr);

    pc_fetch_unit u_dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .imem_req         (imem_req),
        .imem_addr        (imem_addr),
        .imem_rdata       (imem_rdata),
        .imem_ack         (imem_ack),
        .stall_d          (stall_d),
        .pc_branch_en_sel (pc_branch_en_sel),
        .branch_target_e  (branch_target_e),
        .instr_d          (instr_d),
        .pc_d             (pc_d),
        .valid_d          (valid_d),
        .fetch_count      (fetch_count)
    );

    pc_fetch_unit #(.RESET_PC(32'hFFFF_FFF8)) u_dut_hi (
        .clk              (clk),
        .rst_n            (rst_n),
        .imem_req         (h_req),
        .imem_addr        (h_addr),
        .imem_rdata       (h_rdata),
        .imem_ack         (h_req),
        .stall_d          (1'b0),
        .pc_branch_en_sel (2'b00),
        .branch_target_e  (32'h0),
        .instr_d          (h_instr),
        .pc_d             (h_pc),
        .valid_d          (h_valid),
        .fetch_count      (h_cnt)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Stream model: deliveries must follow RESET_PC, +4, ... restarting at each taken target,
    // every delivered word must be mem_word(pc), stalls freeze IF/ID, and handshakes hold.
    initial begin : monitor
        logic        p_ok, p_req, p_ack, p_stall, p_valid;
        logic [1:0]  p_sel;
        logic [31:0] p_addr, p_tgt, p_cnt, p_pcd, p_instr, exp_pc;
        p_ok = 1'b0;
        exp_pc = 32'h0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                chk("rst_req",   32'(imem_req), 32'h0);
                chk("rst_valid", 32'(valid_d),  32'h0);
                chk("rst_count", fetch_count,   32'h0);
                p_ok = 1'b0;
                exp_pc = 32'h0;
            end else begin
                if (p_ok) begin
                    if (!valid_d) chk("bubble_nop", instr_d, NOP);
                    if (p_req && !p_ack) begin
                        chk("req_held",    32'(imem_req), 32'h1);
                        chk("addr_stable", imem_addr, p_addr);
                    end
                    if (p_sel == 2'b10) begin
                        chk("redir_bubble", 32'(valid_d), 32'h0);
                        chk("redir_count",  fetch_count, p_cnt);
                        exp_pc = p_tgt & ~32'h3;
                    end else if (fetch_count == p_cnt + 32'd1) begin
                        chk("deliver_valid", 32'(valid_d), 32'h1);
                        chk("deliver_pc",    pc_d, exp_pc);
                        chk("deliver_instr", instr_d, mem_word(exp_pc));
                        exp_pc = exp_pc + 32'd4;
                    end else if (fetch_count == p_cnt) begin
                        if (p_stall && p_valid) begin
                            chk("stall_valid", 32'(valid_d), 32'h1);
                            chk("stall_pc",    pc_d, p_pcd);
                            chk("stall_instr", instr_d, p_instr);
                        end else begin
                            chk("idle_bubble", 32'(valid_d), 32'h0);
                        end
                    end else begin
                        chk("count_step", fetch_count, p_cnt);
                    end
                end
                p_req = imem_req;  p_ack = imem_ack;   p_addr = imem_addr;
                p_sel = pc_branch_en_sel; p_tgt = branch_target_e;
                p_stall = stall_d; p_valid = valid_d;  p_cnt = fetch_count;
                p_pcd = pc_d;      p_instr = instr_d;  p_ok = 1'b1;
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin : stim
        logic [31:0] c0;
        int v;
        rst_n = 1'b0; ws = 0; stall_d = 1'b0;
        pc_branch_en_sel = 2'b00; branch_target_e = 32'h0;
        repeat (2) tick();
        chk("reset_req",   32'(imem_req), 32'h0);
        chk("reset_addr",  imem_addr, 32'h0);
        chk("reset_instr", instr_d, NOP);
        chk("reset_pcd",   pc_d, 32'h0);

        // 1: zero-wait sequential fetch
        rst_n = 1'b1;
        tick(); chk("t1_req_rise", 32'(imem_req), 32'h1); chk("t1_addr0", imem_addr, 32'h0);
        tick(); chk("t1_pcd0", pc_d, 32'h0); chk("t1_instr0", instr_d, 32'hC0DE_0000);
                chk("t1_addr4", imem_addr, 32'h4);
        tick(); chk("t1_pcd4", pc_d, 32'h4);
        tick(); chk("t1_pcd8", pc_d, 32'h8); chk("t1_count3", fetch_count, 32'd3);
                chk("t1_instr8", instr_d, 32'hC0DE_0008);

        // 2: two wait states
        ws = 2;
        tick(); chk("t2_bub1", 32'(valid_d), 32'h0); chk("t2_addr_a", imem_addr, 32'hC);
        tick(); chk("t2_bub2", 32'(valid_d), 32'h0); chk("t2_addr_b", imem_addr, 32'hC);
        tick(); chk("t2_pcdC", pc_d, 32'hC); chk("t2_count4", fetch_count, 32'd4);

        // 3: stall across an ack
        ws = 0; stall_d = 1'b1;
        tick(); chk("t3_req_drop", 32'(imem_req), 32'h0); chk("t3_hold_pc", pc_d, 32'hC);
        tick(); tick();
        chk("t3_frozen_pc", pc_d, 32'hC); chk("t3_frozen_cnt", fetch_count, 32'd4);
        stall_d = 1'b0;
        tick(); chk("t3_skid_pc", pc_d, 32'h10); chk("t3_count5", fetch_count, 32'd5);
                chk("t3_next_addr", imem_addr, 32'h14);
        tick(); chk("t3_pc14", pc_d, 32'h14); chk("t3_count6", fetch_count, 32'd6);

        // 4: taken branch while a request is pending
        ws = 3;
        tick();
        pc_branch_en_sel = 2'b10; branch_target_e = 32'h103;
        tick(); chk("t4_drain_req", 32'(imem_req), 32'h1); chk("t4_drain_addr", imem_addr, 32'h18);
        pc_branch_en_sel = 2'b00;
        tick(); chk("t4_drain_addr2", imem_addr, 32'h18);
        tick(); chk("t4_target_addr", imem_addr, 32'h100); chk("t4_drop_cnt", fetch_count, 32'd6);
                chk("t4_bubble", 32'(valid_d), 32'h0);
        ws = 0;
        tick(); chk("t4_pc100", pc_d, 32'h100); chk("t4_count7", fetch_count, 32'd7);

        // 5: taken branch coincident with ack and stall
        pc_branch_en_sel = 2'b10; branch_target_e = 32'h200; stall_d = 1'b1;
        tick(); chk("t5_bubble", 32'(valid_d), 32'h0); chk("t5_nop", instr_d, NOP);
                chk("t5_addr", imem_addr, 32'h200); chk("t5_count", fetch_count, 32'd7);
        pc_branch_en_sel = 2'b00; stall_d = 1'b0;
        tick(); chk("t5_pc200", pc_d, 32'h200); chk("t5_instr", instr_d, 32'hC0DE_0200);
                chk("t5_count8", fetch_count, 32'd8);

        // 6: reset asserted mid-DRAIN, then high reset vector wrap
        ws = 3;
        tick();
        pc_branch_en_sel = 2'b10; branch_target_e = 32'h300;
        tick(); chk("t6_in_drain", imem_addr, 32'h204);
        pc_branch_en_sel = 2'b00;
        #1 rst_n = 1'b0;
        #1;
        chk("t6_rst_req", 32'(imem_req), 32'h0); chk("t6_rst_addr", imem_addr, 32'h0);
        chk("t6_rst_instr", instr_d, NOP); chk("t6_rst_pcd", pc_d, 32'h0);
        chk("t6_rst_valid", 32'(valid_d), 32'h0); chk("t6_rst_cnt", fetch_count, 32'h0);
        ws = 0;
        tick(); tick();
        rst_n = 1'b1;
        tick(); chk("t6_hi_a0", h_addr, 32'hFFFF_FFF8); chk("t6_hi_req", 32'(h_req), 32'h1);
        tick(); chk("t6_hi_p0", h_pc, 32'hFFFF_FFF8); chk("t6_hi_a1", h_addr, 32'hFFFF_FFFC);
        tick(); chk("t6_hi_p1", h_pc, 32'hFFFF_FFFC); chk("t6_hi_a2", h_addr, 32'h0);
        tick(); chk("t6_hi_p2", h_pc, 32'h0); chk("t6_hi_i2", h_instr, 32'hC0DE_0000);

        // Mixed traffic under the stream model
        c0 = fetch_count;
        repeat (400) begin
            stall_d = ($urandom_range(0, 3) == 0);
            ws = $urandom_range(0, 2);
            if ($urandom_range(0, 15) == 0) begin
                pc_branch_en_sel = 2'b10;
                branch_target_e = $urandom;
            end else begin
                v = $urandom_range(0, 2);
                pc_branch_en_sel = (v == 2) ? 2'b11 : 2'(v);
            end
            tick();
        end
        pc_branch_en_sel = 2'b00; stall_d = 1'b0;
        tick();
        chk("progress", 32'(fetch_count > c0), 32'h1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
